// File: rtl/cross_product_q.sv
// Streaming signed Q-format 3-vector cross product, out = x cross y.
// Two pipeline registers feed a show-ahead output FIFO; input pops are credit-limited by FIFO space.
module cross_product_q #(
  parameter int Q_BITS         = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][DATA_WIDTH-1:0] x,
  input  logic [2:0][DATA_WIDTH-1:0] y,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic                       out_empty,
  input  logic                       out_rd_en,
  output logic [2:0][DATA_WIDTH-1:0] out
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Full-width signed product, floor-shifted by Q_BITS, low DATA_WIDTH bits kept.
  function automatic logic [DATA_WIDTH-1:0] qmul(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] ae;
    logic signed [2*DATA_WIDTH-1:0] be;
    logic signed [2*DATA_WIDTH-1:0] p;
    ae = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    be = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    p  = ae * be;
    p  = p >>> Q_BITS;
    return p[DATA_WIDTH-1:0];
  endfunction

  logic [2:0][DATA_WIDTH-1:0] w_pa;
  logic [2:0][DATA_WIDTH-1:0] w_pb;
  logic [2:0][DATA_WIDTH-1:0] r_s1_a;
  logic [2:0][DATA_WIDTH-1:0] r_s1_b;
  logic [2:0][DATA_WIDTH-1:0] r_s2_res;
  logic                       r_s1_vld;
  logic                       r_s2_vld;

  logic [2:0][DATA_WIDTH-1:0] r_mem [OUT_FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;

  logic [CW-1:0]              w_inflight;
  logic                       w_full;
  logic                       w_wr;
  logic                       w_rd;

  always_comb begin
    w_pa[0] = qmul(x[1], y[2]);
    w_pb[0] = qmul(x[2], y[1]);
    w_pa[1] = qmul(x[2], y[0]);
    w_pb[1] = qmul(x[0], y[2]);
    w_pa[2] = qmul(x[0], y[1]);
    w_pb[2] = qmul(x[1], y[0]);
  end

  assign w_inflight = CW'(r_s1_vld) + CW'(r_s2_vld);
  assign w_full     = (r_count == CW'(OUT_FIFO_DEPTH));
  assign out_empty  = (r_count == '0);
  assign w_wr       = r_s2_vld && !w_full;
  assign w_rd       = out_rd_en && !out_empty;

  // Gated by reset so the pop strobe drops the instant reset asserts.
  assign in_rd_en = reset && !in_empty &&
                    ((r_count + w_inflight) <= CW'(OUT_FIFO_DEPTH - 1));

  assign out = out_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= in_rd_en;
      r_s2_vld <= r_s1_vld;
    end
  end

  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      r_s1_a <= w_pa;
      r_s1_b <= w_pb;
    end
    if (r_s1_vld) begin
      for (int i = 0; i < 3; i++) r_s2_res[i] <= r_s1_a[i] - r_s1_b[i];
    end
    if (w_wr) r_mem[r_wr_ptr] <= r_s2_res;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cross_product_q.sv
// Scoreboard bench for cross_product_q: an upstream FIFO model pushes expected results on each pop,
// a monitor compares them against the DUT output FIFO head on each consumer read.
module tb_cross_product_q;
  localparam int W = 32;
  localparam int D = 16;

  typedef logic [2:0][W-1:0] vec_t;
  typedef struct {
    vec_t vx;
    vec_t vy;
    vec_t ve;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  vec_t x, y, out;
  logic in_empty, in_rd_en, out_empty, out_rd_en;

  item_t src_q[$];
  vec_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    pops     = 0;
  int    reads    = 0;
  bit    hold     = 1'b0;

  always #5 clock = ~clock;

  cross_product_q #(.Q_BITS(16), .DATA_WIDTH(W), .OUT_FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_empty(out_empty), .out_rd_en(out_rd_en), .out(out)
  );

  task automatic check(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] tq(input logic [W-1:0] p, input logic [W-1:0] q);
    longint r;
    r = longint'($signed(p)) * longint'($signed(q));
    r = r >>> 16;
    return r[W-1:0];
  endfunction

  function automatic vec_t model(input vec_t a, input vec_t b);
    vec_t m;
    m[0] = tq(a[1], b[2]) - tq(a[2], b[1]);
    m[1] = tq(a[2], b[0]) - tq(a[0], b[2]);
    m[2] = tq(a[0], b[1]) - tq(a[1], b[0]);
    return m;
  endfunction

  task automatic drive();
    in_empty = hold || (src_q.size() == 0);
    if (src_q.size() != 0) begin
      x = src_q[0].vx;
      y = src_q[0].vy;
    end else begin
      x = '0;
      y = '0;
    end
  endtask

  task automatic push(input vec_t a, input vec_t b, input vec_t e);
    item_t it;
    it.vx = a;
    it.vy = b;
    it.ve = e;
    src_q.push_back(it);
    drive();
  endtask

  task automatic push_rand(input int n);
    vec_t a, b;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        a[k] = $urandom;
        b[k] = $urandom;
      end
      push(a, b, model(a, b));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic drain(input string name, output int n);
    out_rd_en = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || !out_empty) && n < 5000) begin
      wait_cyc(1);
      n++;
    end
    check({"drain_done_", name}, 96'(n < 5000), 96'(1));
    out_rd_en = 1'b0;
  endtask

  // Upstream FIFO model: the pop decision is taken between edges and committed on the edge.
  initial begin
    bit do_pop;
    forever begin
      @(negedge clock);
      do_pop = in_rd_en && !in_empty;
      if (in_rd_en && in_empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_while_empty actual=1 required=0");
      end
      @(posedge clock);
      #1;
      if (do_pop && reset) begin
        exp_q.push_back(src_q[0].ve);
        void'(src_q.pop_front());
        pops++;
      end
      drive();
    end
  end

  // Monitor: compare on every accepted consumer read, and watch the occupancy credit.
  initial begin
    vec_t e;
    forever begin
      @(negedge clock);
      if (reset && (pops - reads > D)) begin
        n_checks++;
        n_fail++;
        $display("FAIL occupancy actual=%0d required<=%0d", pops - reads, D);
      end
      if (reset && !out_empty && out_rd_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result actual=%h required=none", out);
        end else begin
          e = exp_q.pop_front();
          check("result", out, e);
        end
        reads++;
      end
    end
  end

  initial begin
    int n, p0, r0;
    x = '0;
    y = '0;
    in_empty = 1'b0;
    out_rd_en = 1'b0;
    #1;
    check("rst_out_empty", 96'(out_empty), 96'(1));
    check("rst_in_rd_en", 96'(in_rd_en), 96'(0));
    check("rst_out", out, '0);
    in_empty = 1'b1;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);

    // Basis vectors and pop-to-visible latency
    p0 = pops;
    push({32'h0, 32'h0, 32'h0001_0000}, {32'h0, 32'h0001_0000, 32'h0},
         {32'h0001_0000, 32'h0, 32'h0});
    n = 0;
    while (pops == p0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("basis_popped", 96'(pops - p0), 96'(1));
    check("lat_edge0_empty", 96'(out_empty), 96'(1));
    @(negedge clock);
    check("lat_edge1_empty", 96'(out_empty), 96'(1));
    @(negedge clock);
    check("lat_edge2_empty", 96'(out_empty), 96'(0));
    check("basis_head", out, {32'h0001_0000, 32'h0, 32'h0});
    wait_cyc(1);
    drain("basis", n);

    // Integers, truncation toward -inf, and wrap-around overflow
    push({32'h0004_0000, 32'h0003_0000, 32'h0002_0000}, {32'h0007_0000, 32'h0006_0000, 32'h0005_0000},
         {32'hFFFD_0000, 32'h0006_0000, 32'hFFFD_0000});
    push({32'h0, 32'hFFFF_FFFF, 32'h0}, {32'h0000_0001, 32'h0, 32'h0}, {32'h0, 32'h0, 32'hFFFF_FFFF});
    push({32'h0, 32'h0000_0001, 32'h0}, {32'h0000_0001, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0});
    push({32'h0, 32'h0, 32'h7FFF_0000}, {32'h0, 32'h7FFF_0000, 32'h0}, {32'h0001_0000, 32'h0, 32'h0});
    push({32'h0, 32'h7FFF_0000, 32'h0}, {32'h8000_0000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h8000_0000});
    drain("directed", n);

    // Back-pressure: consumer idle, exactly D pops then stall
    p0 = pops;
    push_rand(40);
    wait_cyc(60);
    check("bp_pops", 96'(pops - p0), 96'(D));
    check("bp_in_rd_en", 96'(in_rd_en), 96'(0));
    check("bp_in_empty", 96'(in_empty), 96'(0));
    check("bp_out_empty", 96'(out_empty), 96'(0));
    drain("backpressure", n);
    check("bp_reads", 96'(reads - p0), 96'(40));

    // Streaming: 1000 pairs, consumer reading every cycle
    r0 = reads;
    push_rand(1000);
    drain("stream", n);
    check("stream_reads", 96'(reads - r0), 96'(1000));
    check("stream_rate", 96'(n <= 1008), 96'(1));

    // Reset mid-stream with 5 results buffered
    push_rand(5);
    wait_cyc(10);
    check("pre_rst_buffered", 96'(pops - reads), 96'(5));
    hold = 1'b1;
    push_rand(2);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out_empty", 96'(out_empty), 96'(1));
    check("mid_rst_out", out, '0);
    hold = 1'b0;
    drive();
    #1;
    check("mid_rst_in_rd_en", 96'(in_rd_en), 96'(0));
    exp_q.delete();
    src_q.delete();
    drive();
    pops = 0;
    reads = 0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
    check("post_rst_out_empty", 96'(out_empty), 96'(1));
    push({32'h0004_0000, 32'h0003_0000, 32'h0002_0000}, {32'h0007_0000, 32'h0006_0000, 32'h0005_0000},
         {32'hFFFD_0000, 32'h0006_0000, 32'hFFFD_0000});
    push_rand(6);
    drain("post_reset", n);
    check("post_rst_reads", 96'(reads), 96'(7));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
